// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache: hits answer the next cycle,
// misses refill a whole line from backing memory over a req/ack handshake.
module icache_fetch #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_instr,
  output logic        cpu_valid,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int INDEX_W  = $clog2(LINES);
  localparam int OFFSET_W = $clog2(WORDS);
  localparam int TAG_W    = 32 - 2 - OFFSET_W - INDEX_W;
  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                flushed_q, flushed_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                cpu_valid_q, cpu_valid_d;
  logic [31:0]         cpu_instr_q, cpu_instr_d;

  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic [INDEX_W-1:0]  req_idx_q, req_idx_d;
  logic [OFFSET_W-1:0] req_off_q, req_off_d;
  logic [31:0]         crit_q, crit_d;

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [31:0]         data_mem [LINES*WORDS];

  logic [TAG_W-1:0]    a_tag;
  logic [INDEX_W-1:0]  a_idx;
  logic [OFFSET_W-1:0] a_off;
  logic                hit, ack, data_we, tag_we;
  logic                unused_addr_bits;

  assign a_off = cpu_addr[OFFSET_W+1:2];
  assign a_idx = cpu_addr[OFFSET_W+INDEX_W+1:OFFSET_W+2];
  assign a_tag = cpu_addr[31:OFFSET_W+INDEX_W+2];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // A same-cycle flush invalidates before the lookup, so it forces a miss.
  assign hit = valid_q[a_idx] && (tag_mem[a_idx] == a_tag) && !flush;
  assign ack = mem_ack && mem_req_q;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    flushed_d   = flushed_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    cpu_valid_d = 1'b0;
    cpu_instr_d = cpu_instr_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    req_off_d   = req_off_q;
    crit_d      = crit_q;
    data_we     = 1'b0;
    tag_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            cpu_valid_d = 1'b1;
            cpu_instr_d = data_mem[{a_idx, a_off}];
          end else begin
            req_tag_d  = a_tag;
            req_idx_d  = a_idx;
            req_off_d  = a_off;
            cnt_d      = '0;
            flushed_d  = 1'b0;
            mem_req_d  = 1'b1;
            mem_addr_d = {a_tag, a_idx, {OFFSET_W{1'b0}}, 2'b00};
            state_d    = REFILL;
          end
        end
      end

      REFILL: begin
        if (flush) flushed_d = 1'b1;
        if (ack) begin
          data_we = 1'b1;
          cnt_d   = cnt_inc;
          // Keep the requested word aside so RESPOND needs no array read.
          if (cnt_q == req_off_q) crit_d = mem_rdata;
          if (cnt_q == LAST_WORD) begin
            mem_req_d = 1'b0;
            tag_we    = 1'b1;
            state_d   = RESPOND;
            if (!flushed_q) valid_d[req_idx_q] = 1'b1;
          end else begin
            mem_addr_d = {req_tag_q, req_idx_q, cnt_inc, 2'b00};
          end
        end
      end

      RESPOND: begin
        cpu_valid_d = 1'b1;
        cpu_instr_d = crit_q;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      flushed_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      cpu_valid_q <= 1'b0;
      cpu_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      flushed_q   <= flushed_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      cpu_valid_q <= cpu_valid_d;
      cpu_instr_q <= cpu_instr_d;
    end
  end

  // Request latches and storage arrays carry no reset; valid_q guards them.
  always_ff @(posedge clk) begin
    req_tag_q <= req_tag_d;
    req_idx_q <= req_idx_d;
    req_off_q <= req_off_d;
    crit_q    <= crit_d;
    if (data_we) data_mem[{req_idx_q, cnt_q}] <= mem_rdata;
    if (tag_we) tag_mem[req_idx_q] <= req_tag_q;
  end

  assign cpu_valid = cpu_valid_q;
  assign cpu_instr = cpu_instr_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: a backing-memory model that returns data = address
// with programmable wait states, and a queue of expected fetch results.
module tb_icache_fetch;
  localparam int WORDS = 4;

  logic        clk, reset, cpu_req, flush, mem_ack, cpu_valid, mem_req;
  logic [31:0] cpu_addr, cpu_instr, mem_addr, mem_rdata;
  int          checks = 0;
  int          errors = 0;
  int          mem_wait = 0;
  int          wcnt = 0;
  logic [31:0] mem_log [$];
  logic [31:0] exp_q [$];
  typedef struct { logic req; logic [31:0] addr; } trace_t;
  trace_t      trace [$];

  icache_fetch #(.LINES(16), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_instr(cpu_instr), .cpu_valid(cpu_valid), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory answers 1ns after the falling edge, ready for the next rising edge.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req === 1'b1) begin
        if (wcnt >= mem_wait) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr;
          mem_log.push_back(mem_addr);
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic request(input logic [31:0] a);
    cpu_addr = a;
    cpu_req = 1'b1;
    exp_q.push_back({a[31:2], 2'b00});
  endtask

  // Runs until cpu_valid or max_cyc; optionally drops cpu_req or pulses flush
  // after a given number of cycles (0 = together with the request).
  task automatic run(input int max_cyc, input int drop_at, input int flush_at,
                     output int lat, output bit seen);
    trace.delete();
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < max_cyc) begin
      flush = (lat == flush_at);
      if (lat == drop_at) cpu_req = 1'b0;
      tick();
      lat++;
      trace.push_back('{mem_req, mem_addr});
      if (cpu_valid === 1'b1) begin
        seen = 1'b1;
        cpu_req = 1'b0;
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
    repeat (2) tick();
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL reset_cpu_valid: got %b, expected 0", cpu_valid); end
    checks++; if (cpu_instr !== 32'h0) begin errors++; $display("FAIL reset_cpu_instr: got %h, expected 0", cpu_instr); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b, expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h, expected 0", mem_addr); end
    reset = 1'b0;
    tick();
    checks++; if (cpu_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got valid=%b req=%b, expected 0 0", cpu_valid, mem_req); end
  endtask

  task automatic test_cold_miss();
    int lat; bit seen; logic [31:0] want; logic want_req;
    mem_wait = 0; mem_log.delete();
    request(32'h8002_0008);
    run(20, -1, -1, lat, seen);
    checks++; if (!seen || lat != 6) begin errors++; $display("FAIL cold_latency: got %0d cycles (seen=%b), expected 6", lat, seen); end
    want = exp_q.pop_front();
    checks++; if (cpu_instr !== want) begin errors++; $display("FAIL cold_instr: got %h, expected %h", cpu_instr, want); end
    foreach (trace[t]) begin
      want_req = (t < WORDS);
      checks++;
      if (trace[t].req !== want_req || (want_req && trace[t].addr !== 32'h8002_0000 + 32'(4 * t)))
        begin errors++; $display("FAIL cold_mem_cycle%0d: got req=%b addr=%h, expected req=%b addr=%h", t + 1, trace[t].req, trace[t].addr, want_req, 32'h8002_0000 + 32'(4 * t)); end
    end
    checks++; if (mem_log.size() != WORDS) begin errors++; $display("FAIL cold_reads: got %0d, expected %0d", mem_log.size(), WORDS); end
  endtask

  task automatic test_hits();
    logic [31:0] want;
    mem_log.delete();
    request(32'h8002_0000);
    tick();
    checks++; if (cpu_valid !== 1'b1) begin errors++; $display("FAIL hit0_valid: got %b, expected 1", cpu_valid); end
    want = exp_q.pop_front();
    checks++; if (cpu_instr !== want) begin errors++; $display("FAIL hit0_instr: got %h, expected %h", cpu_instr, want); end
    request(32'h8002_000C);
    tick();
    checks++; if (cpu_valid !== 1'b1) begin errors++; $display("FAIL hit1_valid: got %b, expected 1", cpu_valid); end
    want = exp_q.pop_front();
    checks++; if (cpu_instr !== want) begin errors++; $display("FAIL hit1_instr: got %h, expected %h", cpu_instr, want); end
    cpu_req = 1'b0;
    tick();
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL hit_idle_valid: got %b, expected 0", cpu_valid); end
    checks++; if (mem_req !== 1'b0 || mem_log.size() != 0) begin errors++; $display("FAIL hit_no_mem: got req=%b reads=%0d, expected 0 0", mem_req, mem_log.size()); end
  endtask

  task automatic test_wait_conflict();
    int lat; bit seen; logic [31:0] want; logic want_req; logic [31:0] want_addr;
    mem_wait = 3; mem_log.delete();
    request(32'h8002_0100);
    run(60, -1, -1, lat, seen);
    checks++; if (!seen || lat != 18) begin errors++; $display("FAIL wait_latency: got %0d cycles (seen=%b), expected 18", lat, seen); end
    want = exp_q.pop_front();
    checks++; if (cpu_instr !== want) begin errors++; $display("FAIL wait_instr: got %h, expected %h", cpu_instr, want); end
    foreach (trace[t]) begin
      want_req = (t < 4 * WORDS);
      want_addr = 32'h8002_0100 + 32'(4 * (t / 4));
      checks++;
      if (trace[t].req !== want_req || (want_req && trace[t].addr !== want_addr))
        begin errors++; $display("FAIL wait_mem_cycle%0d: got req=%b addr=%h, expected req=%b addr=%h", t + 1, trace[t].req, trace[t].addr, want_req, want_addr); end
    end
    mem_wait = 0; mem_log.delete();
    request(32'h8002_0000);
    run(20, -1, -1, lat, seen);
    checks++; if (!seen || lat != 6) begin errors++; $display("FAIL conflict_latency: got %0d cycles, expected 6", lat); end
    want = exp_q.pop_front();
    checks++; if (cpu_instr !== want) begin errors++; $display("FAIL conflict_instr: got %h, expected %h", cpu_instr, want); end
    checks++; if (mem_log.size() != WORDS || mem_log[0] !== 32'h8002_0000) begin errors++; $display("FAIL conflict_reads: got %0d reads, expected %0d from 80020000", mem_log.size(), WORDS); end
  endtask

  task automatic test_flush();
    logic [31:0] addr_t [7];
    int fl_t [7], lat_t [7], rd_t [7];
    int lat; bit seen; logic [31:0] want;
    addr_t = '{32'h8002_0000, 32'h8002_0040, 32'h8002_0040, 32'h8002_0040,
               32'h8002_0040, 32'h8002_00E4, 32'h8002_00E4};
    fl_t   = '{-1, 2, -1, -1, 0, 5, -1};
    lat_t  = '{6, 6, 6, 1, 6, 6, 6};
    rd_t   = '{4, 4, 4, 0, 4, 4, 4};
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int s = 0; s < 7; s++) begin
      mem_log.delete();
      request(addr_t[s]);
      run(20, -1, fl_t[s], lat, seen);
      checks++; if (!seen || lat != lat_t[s]) begin errors++; $display("FAIL flush_step%0d_latency: got %0d cycles, expected %0d", s, lat, lat_t[s]); end
      want = exp_q.pop_front();
      checks++; if (cpu_instr !== want) begin errors++; $display("FAIL flush_step%0d_instr: got %h, expected %h", s, cpu_instr, want); end
      checks++; if (mem_log.size() != rd_t[s]) begin errors++; $display("FAIL flush_step%0d_reads: got %0d, expected %0d", s, mem_log.size(), rd_t[s]); end
    end
  endtask

  task automatic test_reset_mid_refill();
    int lat; bit seen; logic [31:0] want;
    mem_wait = 0; mem_log.delete();
    request(32'h8002_0080);
    repeat (3) tick();
    checks++; if (mem_log.size() != 2) begin errors++; $display("FAIL midreset_acks: got %0d, expected 2", mem_log.size()); end
    #2 reset = 1'b1; cpu_req = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || cpu_valid !== 1'b0) begin errors++; $display("FAIL midreset_async: got req=%b valid=%b, expected 0 0", mem_req, cpu_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL midreset_addr: got %h, expected 0", mem_addr); end
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    mem_log.delete();
    request(32'h8002_0080);
    run(20, -1, -1, lat, seen);
    checks++; if (!seen || lat != 6) begin errors++; $display("FAIL midreset_refill_latency: got %0d cycles, expected 6", lat); end
    want = exp_q.pop_front();
    checks++; if (cpu_instr !== want) begin errors++; $display("FAIL midreset_refill_instr: got %h, expected %h", cpu_instr, want); end
    checks++; if (mem_log.size() != WORDS || mem_log[0] !== 32'h8002_0080 || mem_log[WORDS-1] !== 32'h8002_008C)
      begin errors++; $display("FAIL midreset_refill_reads: got %0d reads, expected 80020080..8002008C", mem_log.size()); end
    mem_log.delete();
    request(32'h8002_00E4);
    run(20, -1, -1, lat, seen);
    void'(exp_q.pop_front());
    checks++; if (lat != 6 || mem_log.size() != WORDS) begin errors++; $display("FAIL midreset_lines_invalid: got %0d cycles %0d reads, expected 6 cycles 4 reads", lat, mem_log.size()); end
  endtask

  task automatic test_dropped_req();
    int lat; bit seen; logic [31:0] want;
    mem_log.delete();
    request(32'h8002_00C0);
    run(20, 2, -1, lat, seen);
    checks++; if (!seen || lat != 6) begin errors++; $display("FAIL drop_pulse: got %0d cycles (seen=%b), expected 6", lat, seen); end
    want = exp_q.pop_front();
    checks++; if (cpu_instr !== want) begin errors++; $display("FAIL drop_instr: got %h, expected %h", cpu_instr, want); end
    mem_log.delete();
    request(32'h8002_00C0);
    run(20, -1, -1, lat, seen);
    checks++; if (!seen || lat != 1 || mem_log.size() != 0) begin errors++; $display("FAIL drop_then_hit: got %0d cycles %0d reads, expected 1 cycle 0 reads", lat, mem_log.size()); end
    want = exp_q.pop_front();
    checks++; if (cpu_instr !== want) begin errors++; $display("FAIL drop_hit_instr: got %h, expected %h", cpu_instr, want); end
  endtask

  task automatic test_boundary();
    int lat; bit seen; logic [31:0] want;
    mem_log.delete();
    request(32'hFFFF_FFFC);
    run(20, -1, -1, lat, seen);
    checks++; if (!seen || lat != 6) begin errors++; $display("FAIL top_latency: got %0d cycles, expected 6", lat); end
    want = exp_q.pop_front();
    checks++; if (cpu_instr !== want) begin errors++; $display("FAIL top_instr: got %h, expected %h", cpu_instr, want); end
    checks++; if (mem_log.size() != WORDS || mem_log[0] !== 32'hFFFF_FFF0 || mem_log[WORDS-1] !== 32'hFFFF_FFFC)
      begin errors++; $display("FAIL top_reads: got %0d reads, expected FFFFFFF0..FFFFFFFC", mem_log.size()); end
    request(32'hFFFF_FFF4);
    run(20, -1, -1, lat, seen);
    checks++; if (!seen || lat != 1) begin errors++; $display("FAIL top_hit_latency: got %0d cycles, expected 1", lat); end
    want = exp_q.pop_front();
    checks++; if (cpu_instr !== want) begin errors++; $display("FAIL top_hit_instr: got %h, expected %h", cpu_instr, want); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_wait_conflict();
    test_flush();
    test_reset_mid_refill();
    test_dropped_req();
    test_boundary();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the multi-cycle MIPS core's instruction-fetch side and a slow backing instruction memory.
- Core side: the core drives a word address and request, and receives a registered instruction word with a valid strobe.
- Memory side: misses are refilled a full line at a time over a req/ack handshake, one word per ack.
- Flush input invalidates all lines, e.g. after a program load.

Parameters:
LINES, 16, number of cache lines (power of two, >=2); INDEX_W = log2(LINES)
WORDS, 4, 32-bit words per line (power of two, >=2); OFFSET_W = log2(WORDS)
TAG_W derived: 32 - 2 - OFFSET_W - INDEX_W

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
cpu_req  in  1  fetch request; sampled only in IDLE
cpu_addr  in  32  fetch byte address; bits [1:0] ignored
cpu_instr  out  32  instruction word, meaningful when cpu_valid=1
cpu_valid  out  1  one-cycle strobe per accepted request
flush  in  1  invalidate all lines
mem_req  out  1  backing-memory read request
mem_addr  out  32  word-aligned read address
mem_rdata  in  32  read data, valid when mem_ack=1
mem_ack  in  1  completes the current word read in the same cycle

Behaviour:
- Address split: offset = addr[OFFSET_W+1:2]; index = addr[OFFSET_W+INDEX_W+1:OFFSET_W+2]; tag = upper TAG_W bits.
- Storage per line: valid bit, tag, WORDS data words.
- Reset values: cpu_valid=0, cpu_instr=0, mem_req=0, mem_addr=0, all valid bits=0, state=IDLE. Data and tag arrays need not reset.

States:
- IDLE:
  - cpu_req=1 and hit: next cycle cpu_valid=1, cpu_instr=word; stay IDLE. Back-to-back hits give one result per cycle.
  - cpu_req=1 and miss: latch tag, index and offset; go REFILL; mem_req=1 next cycle with mem_addr={tag,index,0,00}.
  - cpu_req=0: cpu_valid=0.
- REFILL:
  - mem_req is held high with word counter i = 0..WORDS-1; mem_addr = line base + 4*i.
  - On mem_ack: write mem_rdata to word i and increment i. mem_addr advances the next cycle; mem_req stays high.
  - On the ack of the last word: mem_req=0 next cycle; write tag and set valid; go RESPOND.
  - cpu_req and cpu_addr are ignored in this state.
- RESPOND:
  - cpu_valid=1 and cpu_instr = latched word at the latched offset. If the critical word arrives on the same cycle, it is forwarded.
  - Always returns to IDLE.
  - No new request is accepted in this cycle; the core holds or re-presents it.

Latency:
- Hit: request cycle N gives valid at N+1.
- Miss with zero-wait memory (ack same cycle as req): mem_req cycles N+1..N+WORDS, valid at N+WORDS+2.

Handshake rules:
- mem_req never drops mid-line except on reset.
- mem_ack while mem_req=0 is ignored.
- The core must hold cpu_addr stable while cpu_req=1 until cpu_valid. A held cpu_req after cpu_valid is treated as a new request.

Boundary conditions:
- flush in IDLE: all valid bits cleared at the edge. A same-cycle cpu_req is looked up against post-flush state, so it misses.
- flush during REFILL: the refill completes and the word is returned, but the line is NOT marked valid.
- flush during RESPOND: valid bits cleared, including a line just installed.
- cpu_req dropped during REFILL: the refill completes, the line is installed, and RESPOND still pulses cpu_valid (the core ignores it).
- Reset mid-refill: mem_req=0 and cpu_valid=0 immediately (asynchronous), all lines invalid, state IDLE, partial line discarded.
- Last-index and last-offset addresses need no special handling; the counter wraps only within a line.
- Conflict miss (same index, different tag): the line is overwritten.

Test Plan:
- Cold miss: after reset, cpu_req with addr 0x80020008; memory acks each word immediately with data = address. Required: mem_addr 0x80020000, 04, 08, 0C on consecutive cycles, then cpu_valid with cpu_instr=0x80020008 at request+6.
- Hits: after the cold miss, requests 0x80020000, 0x8002000C on consecutive cycles. Required: cpu_valid on two consecutive cycles with 0x80020000 and 0x8002000C, mem_req stays 0.
- Wait states and conflict: mem_ack delayed 3 cycles per word; request 0x80020100 (same index as 0x80020000, LINES=16, WORDS=4).
  - mem_req stays high and mem_addr holds for each wait.
  - The line is refilled from 0x80020100, and cpu_instr=0x80020100.
  - A re-request of 0x80020000 then misses.
- Flush: assert flush for 1 cycle after a line is cached, then request the same address. Required: miss with 4 mem reads. A further test asserts flush mid-refill; the same address then misses again.
- Reset mid-refill: assert reset after the 2nd ack. Required: mem_req=0 and cpu_valid=0 before the next edge; a subsequent request to that line performs a full 4-word refill.
- Dropped request: cpu_req deasserted during REFILL. Required: the refill completes and a later request to that line hits with 1-cycle latency.
